// File: rtl/bcd_convert_sched.sv
// Two-port round-robin front end sharing one bit-serial shift-and-add-3
// binary-to-BCD converter; saturates to all nines above DIGITS digits.
module bcd_convert_sched #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [WIDTH-1:0]    bin0,
  input  logic [WIDTH-1:0]    bin1,
  output logic [1:0]          ack,
  output logic                busy,
  output logic                done,
  output logic                done_id,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = d;
    for (int k = 0; k < DIGITS; k++)
      if (d[4*k +: 4] >= 4'd5) r[4*k +: 4] = d[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [BW-1:0] sat_res(input logic ov, input logic [BW-1:0] d);
    return ov ? {DIGITS{4'h9}} : d;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             last;
  logic             gid;
  logic             ov_q;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0]    dig;
  logic [CW-1:0]    cnt;

  logic             gsel;
  logic [WIDTH-1:0] gop;
  logic             gov;
  logic [BW-1:0]    nxt_dig;

  always_comb begin
    gsel = ~last;
    if (req == 2'b01)      gsel = 1'b0;
    else if (req == 2'b10) gsel = 1'b1;
    gop     = gsel ? bin1 : bin0;
    gov     = ({{(64-WIDTH){1'b0}}, gop} > MAXV);
    nxt_dig = (add3(dig) << 1) | {{(BW-1){1'b0}}, sr[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      gid     <= 1'b0;
      ov_q    <= 1'b0;
      sr      <= '0;
      dig     <= '0;
      cnt     <= '0;
      ack     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      ack  <= 2'b00;
      done <= 1'b0;
      case (state)
        SHIFT: begin
          dig <= nxt_dig;
          sr  <= sr << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state   <= DONE;
            bcd     <= sat_res(ov_q, nxt_dig);
            ovf     <= ov_q;
            done_id <= gid;
            done    <= 1'b1;
          end
        end
        // DONE arbitrates like IDLE so a waiting request is captured on the
        // return edge, keeping back-to-back conversions WIDTH+1 cycles apart.
        IDLE, DONE: begin
          if (|req) begin
            state <= SHIFT;
            busy  <= 1'b1;
            ack   <= gsel ? 2'b10 : 2'b01;
            last  <= gsel;
            gid   <= gsel;
            ov_q  <= gov;
            sr    <= gop;
            dig   <= '0;
            cnt   <= CW'(WIDTH - 1);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
